// File: rtl/mod_writeback.sv
// Writeback stage: buffers EX/WB bundles in a small FIFO and retires them in order
// through the single regfile write port. IMUL retires as two writes (RAX, then RDX).
module mod_writeback #(
    parameter int DEPTH = 2,
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        enable_writeback,
    input  logic [1:0]  dep_exwb,
    input  logic [3:0]  regByte_contents_exwb,
    input  logic [3:0]  rmByte_contents_exwb,
    input  logic [7:0]  opcode_exwb,
    input  logic [63:0] alu_result_exwb,
    input  logic [63:0] alu_ext_result_exwb,
    input  logic [63:0] rip_exwb,
    input  logic        sim_end_signal_exwb,
    input  logic [63:0] rflags_in,
    input  logic        flags_we,
    output logic        reg_wr_en,
    output logic [3:0]  reg_wr_idx,
    output logic [63:0] reg_wr_data,
    output logic        sb_clear,
    output logic [3:0]  sb_clear_idx,
    output logic [63:0] rflags_seq,
    output logic [63:0] retired_rip,
    output logic [63:0] retire_count,
    output logic        sim_done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] OP_IMUL = 8'd247;

    typedef struct packed {
        logic        en;
        logic [3:0]  dst;
        logic [7:0]  opcode;
        logic [63:0] alu;
        logic [63:0] ext;
        logic [63:0] rip;
        logic        sim_end;
        logic [63:0] rflags;
        logic        flags_we;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RETIRE, IMUL_HI} state_t;

    entry_t           mem_q [DEPTH];
    entry_t           head;
    entry_t           in_entry;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;
    logic [63:0]      rflags_q, rflags_d;
    logic [63:0]      rip_q, rip_d;
    logic [63:0]      rcount_q, rcount_d;
    logic             done_q, done_d;
    logic             push, pop, flush, idx_ok, is_imul;

    assign head     = mem_q[rd_ptr_q];
    assign in_entry = '{en:       enable_writeback,
                        dst:      (dep_exwb == 2'd2) ? regByte_contents_exwb : rmByte_contents_exwb,
                        opcode:   opcode_exwb,
                        alu:      alu_result_exwb,
                        ext:      alu_ext_result_exwb,
                        rip:      rip_exwb,
                        sim_end:  sim_end_signal_exwb,
                        rflags:   rflags_in,
                        flags_we: flags_we};

    assign ex_ready = (32'(count_q) < DEPTH) && !done_q;
    assign push     = ex_valid && ex_ready;
    assign idx_ok   = 32'(head.dst) < NREGS;
    assign is_imul  = head.en && (head.opcode == OP_IMUL);

    always_comb begin
        reg_wr_en    = 1'b0;
        reg_wr_idx   = 4'd0;
        reg_wr_data  = 64'd0;
        sb_clear     = 1'b0;
        sb_clear_idx = 4'd0;
        pop          = 1'b0;
        case (state_q)
            RETIRE: begin
                if (is_imul) begin
                    reg_wr_en   = 1'b1;
                    reg_wr_data = head.alu;
                end else if (head.en) begin
                    reg_wr_en    = idx_ok;
                    reg_wr_idx   = idx_ok ? head.dst : 4'd0;
                    reg_wr_data  = idx_ok ? head.alu : 64'd0;
                    sb_clear     = idx_ok;
                    sb_clear_idx = idx_ok ? head.dst : 4'd0;
                    pop          = 1'b1;
                end else begin
                    pop = 1'b1;
                end
            end
            IMUL_HI: begin
                // RDX is released inside the scoreboard for IMUL, so only index 0 is cleared here
                reg_wr_en    = 1'b1;
                reg_wr_idx   = 4'd2;
                reg_wr_data  = head.ext;
                sb_clear     = 1'b1;
                pop          = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        flush    = pop && head.sim_end;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        // Final instruction retires: discard everything behind it, including a same-cycle push
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        if (state_q == RETIRE && is_imul) begin
            state_d = IMUL_HI;
        end else begin
            state_d = (count_d != '0) ? RETIRE : IDLE;
        end
        rflags_d = rflags_q;
        rip_d    = rip_q;
        rcount_d = rcount_q;
        done_d   = done_q | flush;
        if (pop) begin
            rip_d    = head.rip;
            rcount_d = rcount_q + 64'd1;
            if (head.flags_we) begin
                rflags_d = (head.rflags | 64'h2) & ~64'h28;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            rflags_q <= 64'h2;
            rip_q    <= 64'd0;
            rcount_q <= 64'd0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            rflags_q <= rflags_d;
            rip_q    <= rip_d;
            rcount_q <= rcount_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign rflags_seq   = rflags_q;
    assign retired_rip  = rip_q;
    assign retire_count = rcount_q;
    assign sim_done     = done_q;

endmodule

// File: tb/tb_mod_writeback.sv
// Scoreboard bench for mod_writeback: directed bundles push expected regfile writes,
// an independent monitor pops and compares on every write strobe.
module tb_mod_writeback;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        enable_writeback;
    logic [1:0]  dep_exwb;
    logic [3:0]  regByte_contents_exwb;
    logic [3:0]  rmByte_contents_exwb;
    logic [7:0]  opcode_exwb;
    logic [63:0] alu_result_exwb;
    logic [63:0] alu_ext_result_exwb;
    logic [63:0] rip_exwb;
    logic        sim_end_signal_exwb;
    logic [63:0] rflags_in;
    logic        flags_we;
    logic        reg_wr_en;
    logic [3:0]  reg_wr_idx;
    logic [63:0] reg_wr_data;
    logic        sb_clear;
    logic [3:0]  sb_clear_idx;
    logic [63:0] rflags_seq;
    logic [63:0] retired_rip;
    logic [63:0] retire_count;
    logic        sim_done;

    mod_writeback #(.DEPTH(2), .NREGS(16)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .enable_writeback(enable_writeback), .dep_exwb(dep_exwb),
        .regByte_contents_exwb(regByte_contents_exwb), .rmByte_contents_exwb(rmByte_contents_exwb),
        .opcode_exwb(opcode_exwb), .alu_result_exwb(alu_result_exwb),
        .alu_ext_result_exwb(alu_ext_result_exwb), .rip_exwb(rip_exwb),
        .sim_end_signal_exwb(sim_end_signal_exwb), .rflags_in(rflags_in), .flags_we(flags_we),
        .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
        .sb_clear(sb_clear), .sb_clear_idx(sb_clear_idx), .rflags_seq(rflags_seq),
        .retired_rip(retired_rip), .retire_count(retire_count), .sim_done(sim_done)
    );

    typedef struct {
        logic        en;
        logic [1:0]  dep;
        logic [3:0]  rg;
        logic [3:0]  rm;
        logic [7:0]  op;
        logic [63:0] alu;
        logic [63:0] ext;
        logic [63:0] rip;
        logic        se;
        logic [63:0] rf;
        logic        fwe;
    } bundle_t;

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] data;
        logic        sbc;
        logic [3:0]  sbi;
    } wr_t;

    wr_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    function automatic bundle_t blank();
        bundle_t b;
        b.en = 1'b1; b.dep = 2'd0; b.rg = 4'd0; b.rm = 4'd0; b.op = 8'h8B;
        b.alu = 64'd0; b.ext = 64'd0; b.rip = 64'd0; b.se = 1'b0; b.rf = 64'd0; b.fwe = 1'b0;
        return b;
    endfunction

    function automatic wr_t ew(input logic [3:0] idx, input logic [63:0] data,
                               input logic sbc, input logic [3:0] sbi);
        wr_t e;
        e.idx = idx; e.data = data; e.sbc = sbc; e.sbi = sbi;
        return e;
    endfunction

    task automatic push(input bundle_t b, output int stalls);
        stalls = 0;
        enable_writeback = b.en; dep_exwb = b.dep; regByte_contents_exwb = b.rg;
        rmByte_contents_exwb = b.rm; opcode_exwb = b.op; alu_result_exwb = b.alu;
        alu_ext_result_exwb = b.ext; rip_exwb = b.rip; sim_end_signal_exwb = b.se;
        rflags_in = b.rf; flags_we = b.fwe;
        ex_valid = 1'b1;
        @(negedge clk);
        while (!ex_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!ex_ready) begin
            check("push_accept_timeout", 64'(ex_ready), 64'd1);
            ex_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 ex_valid = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        wr_t e;
        if (reset_n && reg_wr_en) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write idx=%0d data=%h expected=none", reg_wr_idx, reg_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_idx", 64'(reg_wr_idx), 64'(e.idx));
                check("wr_data", reg_wr_data, e.data);
                check("sb_clear", 64'(sb_clear), 64'(e.sbc));
                if (e.sbc) check("sb_clear_idx", 64'(sb_clear_idx), 64'(e.sbi));
            end
        end
    end

    initial begin
        bundle_t b;
        int s0, s1, s2;
        reset_n = 1'b0; ex_valid = 1'b0;
        b = blank();
        enable_writeback = 0; dep_exwb = 0; regByte_contents_exwb = 0; rmByte_contents_exwb = 0;
        opcode_exwb = 0; alu_result_exwb = 0; alu_ext_result_exwb = 0; rip_exwb = 0;
        sim_end_signal_exwb = 0; rflags_in = 0; flags_we = 0;
        wait_cycles(2);
        check("rst_wr_en", 64'(reg_wr_en), 64'd0);
        check("rst_wr_idx", 64'(reg_wr_idx), 64'd0);
        check("rst_wr_data", reg_wr_data, 64'd0);
        check("rst_sb_clear", 64'(sb_clear), 64'd0);
        check("rst_rflags", rflags_seq, 64'h2);
        check("rst_rip", retired_rip, 64'd0);
        check("rst_count", retire_count, 64'd0);
        check("rst_sim_done", 64'(sim_done), 64'd0);
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        @(negedge clk) reset_n = 1'b1;
        wait_cycles(1);

        // Reset in the middle of an IMUL: low half written, high half lost
        b = blank(); b.op = 8'd247; b.alu = 64'h1234; b.ext = 64'h5678; b.rip = 64'h50;
        exp_q.push_back(ew(4'd0, 64'h1234, 1'b0, 4'd0));
        push(b, s0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_wr_en", 64'(reg_wr_en), 64'd0);
        check("midrst_sb_clear", 64'(sb_clear), 64'd0);
        check("midrst_rflags", rflags_seq, 64'h2);
        check("midrst_count", retire_count, 64'd0);
        @(negedge clk) reset_n = 1'b1;
        wait_cycles(3);

        // MOV imm into rm=3
        b = blank(); b.rm = 4'd3; b.alu = 64'hDEAD; b.rip = 64'h100;
        exp_q.push_back(ew(4'd3, 64'hDEAD, 1'b1, 4'd3));
        push(b, s0);
        wait_cycles(1);
        check("mov_count", retire_count, 64'd1);
        check("mov_rip", retired_rip, 64'h100);

        // dep==2 selects reg field; flags forced on commit
        b = blank(); b.dep = 2'd2; b.rg = 4'd5; b.rm = 4'd1; b.alu = 64'd7; b.rip = 64'h110;
        b.fwe = 1'b1; b.rf = 64'hFF;
        exp_q.push_back(ew(4'd5, 64'd7, 1'b1, 4'd5));
        push(b, s0);
        wait_cycles(1);
        check("dep_count", retire_count, 64'd2);
        check("dep_rflags", rflags_seq, 64'hD7);

        // IMUL split into RAX then RDX writes
        b = blank(); b.op = 8'd247; b.alu = 64'h1; b.ext = 64'hFFFF_FFFF_FFFF_FFFF; b.rip = 64'h200;
        exp_q.push_back(ew(4'd0, 64'h1, 1'b0, 4'd0));
        exp_q.push_back(ew(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0));
        push(b, s0);
        @(negedge clk);
        check("imul_ex_ready", 64'(ex_ready), 64'd1);
        wait_cycles(2);
        check("imul_count", retire_count, 64'd3);
        check("imul_rip", retired_rip, 64'h200);

        // Back-pressure behind an IMUL head
        b = blank(); b.op = 8'd247; b.alu = 64'hA0; b.ext = 64'hA1; b.rip = 64'h300;
        exp_q.push_back(ew(4'd0, 64'hA0, 1'b0, 4'd0));
        exp_q.push_back(ew(4'd2, 64'hA1, 1'b1, 4'd0));
        exp_q.push_back(ew(4'd4, 64'h11, 1'b1, 4'd4));
        exp_q.push_back(ew(4'd6, 64'h22, 1'b1, 4'd6));
        push(b, s0);
        b = blank(); b.rm = 4'd4; b.alu = 64'h11; b.rip = 64'h310;
        push(b, s1);
        b = blank(); b.rm = 4'd6; b.alu = 64'h22; b.rip = 64'h320;
        push(b, s2);
        check("bp_second_stalls", 64'(s1), 64'd0);
        check("bp_third_stalls", 64'(s2), 64'd1);
        wait_cycles(3);
        check("bp_count", retire_count, 64'd6);
        check("bp_rip", retired_rip, 64'h320);

        // JE: no write, flags committed
        b = blank(); b.en = 1'b0; b.op = 8'd116; b.fwe = 1'b1; b.rf = 64'h40; b.rip = 64'h400;
        push(b, s0);
        wait_cycles(2);
        check("je_rflags", rflags_seq, 64'h42);
        check("je_count", retire_count, 64'd7);

        // sim_end followed by a bundle that must be dropped
        b = blank(); b.se = 1'b1; b.rm = 4'd0; b.alu = 64'h55; b.rip = 64'h500;
        exp_q.push_back(ew(4'd0, 64'h55, 1'b1, 4'd0));
        push(b, s0);
        b = blank(); b.rm = 4'd7; b.alu = 64'h77; b.rip = 64'h510;
        push(b, s1);
        wait_cycles(3);
        check("end_sim_done", 64'(sim_done), 64'd1);
        check("end_ex_ready", 64'(ex_ready), 64'd0);
        check("end_rip", retired_rip, 64'h500);
        check("end_count", retire_count, 64'd8);
        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

        reset_n = 1'b0;
        #1;
        check("rst2_rflags", rflags_seq, 64'h2);
        check("rst2_sim_done", 64'(sim_done), 64'd0);
        check("rst2_count", retire_count, 64'd0);
        check("rst2_ex_ready", 64'(ex_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mod_writeback.md
Name: mod_writeback

Overview:
Writeback stage of the x86-64 pipeline. It accepts the EX/WB bundle from the execute stage through a valid/ready handshake and buffers it in a 2-entry FIFO. It retires entries in order through the single register-file write port, splitting IMUL into two writes (RAX, then RDX). It also commits RFLAGS, clears scoreboard entries, and latches end-of-simulation.

Parameters:
DEPTH, 2, EX/WB buffer entries (power of two, ≥2)
NREGS, 16, architectural GPR count

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute presents a bundle
ex_ready  out  1  writeback can accept
enable_writeback  in  1  bundle carries a register result
dep_exwb  in  2  destination select (2 = regByte, else rmByte)
regByte_contents_exwb  in  4  reg-field register index
rmByte_contents_exwb  in  4  rm-field register index
opcode_exwb  in  8  primary opcode
alu_result_exwb  in  64  result / IMUL low half
alu_ext_result_exwb  in  64  IMUL high half
rip_exwb  in  64  PC of instruction
sim_end_signal_exwb  in  1  final instruction marker
rflags_in  in  64  flags computed by execute
flags_we  in  1  bundle updates RFLAGS
reg_wr_en  out  1  regfile write strobe
reg_wr_idx  out  4  regfile write index
reg_wr_data  out  64  regfile write data
sb_clear  out  1  scoreboard clear strobe
sb_clear_idx  out  4  register index being released
rflags_seq  out  64  committed RFLAGS
retired_rip  out  64  RIP of last retired instruction
retire_count  out  64  instructions retired
sim_done  out  1  sticky end of simulation

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty, state IDLE.
  - reg_wr_en=0, sb_clear=0, reg_wr_idx=0, reg_wr_data=0.
  - rflags_seq=64'h2 (reserved bit 1 set), retired_rip=0, retire_count=0, sim_done=0.
  - Reset mid-operation discards buffered entries and any pending IMUL high write.
- Accept rule:
  - ex_ready = (count<DEPTH) && !sim_done.
  - Push on a rising edge with ex_valid && ex_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - ex_ready does not depend on same-cycle pop (no pass-through).
- Latency:
  - Entry accepted at edge N appears at the FIFO head in cycle N+1.
  - Write outputs are combinational from head and state; the regfile commits at edge N+1.
  - There is no bypass around the FIFO.
- Destination: dst = (dep==2) ? regByte : rmByte.
- States:
  - IDLE: head empty; all strobes 0.
  - RETIRE: head valid.
    - If enable_writeback=1 and opcode≠247: reg_wr_en=1, idx=dst, data=alu_result, sb_clear=1, sb_clear_idx=dst. Pop, then go to IDLE or stay in RETIRE (next head).
    - If opcode=247 and enable_writeback=1: write idx 0 = alu_result this cycle, no pop, go to IMUL_HI.
    - If enable_writeback=0 (conditional jumps 116/125 etc.): no write, no sb_clear, pop.
  - IMUL_HI: reg_wr_en=1, idx=2, data=alu_ext_result. sb_clear=1, sb_clear_idx=0 (the RDX clear is internal to the scoreboard for 247). Pop.
- On every pop:
  - retired_rip ← rip.
  - retire_count += 1 (wraps at 2^64).
  - If flags_we: rflags_seq ← rflags_in with bit1 forced 1 and bits 3, 5 forced 0.
- sim_end:
  - Popping an entry with sim_end=1 sets sim_done (sticky until reset).
  - Later entries already in the FIFO are dropped without writes.
  - ex_ready=0 thereafter.
- A pop never writes index ≥ NREGS; indices are 4 bits so this is unreachable with NREGS=16.

Test Plan:
- Reset: reset_n low mid-IMUL → all outputs at reset values; rflags_seq=0x2; no write on release.
- MOV imm: push {en=1, dep=0, rm=3, alu=0xDEAD} at edge 0 → cycle 1: reg_wr_en=1, idx=3, data=0xDEAD, sb_clear idx 3; retire_count=1 after edge 1.
- dep select: push {dep=2, reg=5, rm=1, alu=7} → write idx 5, data 7.
- IMUL: push {opcode=247, alu=0x1, ext=0xFFFF_FFFF_FFFF_FFFF} → cycle 1: idx 0 data 1; cycle 2: idx 2 data all-ones; ex_ready stays 1 while count<2; retire_count increments once.
- Back-pressure: 3 back-to-back pushes while the head is an IMUL → ex_ready=0 after 2 entries, third accepted the cycle after the first pop; in-order writes.
- JE plus sim_end: push {opcode=116, en=0, flags_we=1, rflags_in=0x40} → no write, rflags_seq=0x42. Then push {sim_end=1, en=1, rm=0} followed by a second bundle → last write idx 0, sim_done=1, ex_ready=0, second bundle never written.
